cht_seq_ctrl: RTL and testbench

CHT_SEQ_CTRL -- requirements
Module: cht_seq_ctrl

---
 rtl/cht_pkg.sv | 37 +++
 rtl/cht_seq_ctrl_if.sv | 20 ++
 rtl/cht_shift_cnt.sv | 27 ++
 rtl/cht_seq_ctrl.sv | 138 +++++++++++++
 tb/tb_cht_seq_ctrl.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/cht_pkg.sv
// Shared types and default chain lengths for the scan-chain sequencer.
// Op codes, chain selectors and FSM states used by the controller and bench.
package cht_pkg;

   localparam int LEN_A_DEF = 6;
   localparam int LEN_B_DEF = 14;
   localparam int LEN_C_DEF = 16;

   typedef enum logic [1:0] {
      OP_NOP   = 2'b00,
      OP_CLEAR = 2'b01,
      OP_LOAD  = 2'b10,
      OP_SHIFT = 2'b11
   } cht_op_e;

   typedef enum logic [1:0] {
      CH_A   = 2'd0,
      CH_B   = 2'd1,
      CH_C   = 2'd2,
      CH_ALL = 2'd3
   } cht_chain_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLR,
      ST_LOAD,
      ST_SHIFT,
      ST_DONE
   } cht_state_e;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/cht_seq_ctrl_if.sv
// Command handshake bundle between a command source and the sequencer.
interface cht_seq_ctrl_if #(
   parameter int CNT_W = 5
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [1:0]       cmd_chain;
   logic [CNT_W-1:0] cmd_count;

   modport master (
      output cmd_valid, cmd_op, cmd_chain, cmd_count,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_chain, cmd_count,
      output cmd_ready
   );
endinterface

// File: rtl/cht_shift_cnt.sv
// Loadable saturating down-counter that paces SHIFT cycles; zero marks the last one.
module cht_shift_cnt #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (load) begin
         cnt_reg <= load_val;
      end else if (dec && (cnt_reg != '0)) begin
         cnt_reg <= cnt_reg - W'(1);
      end
   end

   assign zero = (cnt_reg == '0);

endmodule

// File: rtl/cht_seq_ctrl.sv
// Scan-chain sequencer: accepts one command at a time and emits registered
// clear / parallel-load / shift strobes for chains A, B and C.
module cht_seq_ctrl
   import cht_pkg::*;
#(
   parameter int LEN_A = LEN_A_DEF,
   parameter int LEN_B = LEN_B_DEF,
   parameter int LEN_C = LEN_C_DEF,
   parameter int CNT_W = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   cht_seq_ctrl_if.slave        cmd,
   input  logic                 abort,
   output logic [2:0]           load_en,
   output logic [2:0]           shift_en,
   output logic                 clear,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   localparam int LEN_MAX = max3(LEN_A, LEN_B, LEN_C);

   cht_state_e       state_reg, state_next;
   logic [2:0]       mask_reg, mask_next;
   logic [2:0]       sel_mask;
   logic             err_next;
   logic             ready_reg;
   logic             accept;
   logic             cnt_load, cnt_dec, cnt_zero;
   logic [CNT_W-1:0] cnt_load_val;
   logic [31:0]      count_ext;
   logic [31:0]      limit;

   assign accept    = cmd.cmd_valid && ready_reg;
   assign count_ext = 32'(cmd.cmd_count);

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_sel
         assign sel_mask[gi] = (cmd.cmd_chain == 2'(gi)) || (cmd.cmd_chain == 2'd3);
      end
   endgenerate

   always_comb begin
      limit = 32'(LEN_MAX);
      case (cht_chain_e'(cmd.cmd_chain))
         CH_A:    limit = 32'(LEN_A);
         CH_B:    limit = 32'(LEN_B);
         CH_C:    limit = 32'(LEN_C);
         default: limit = 32'(LEN_MAX);
      endcase
   end

   cht_shift_cnt #(.W(CNT_W)) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_next   = state_reg;
      mask_next    = mask_reg;
      err_next     = 1'b0;
      cnt_load     = 1'b0;
      cnt_dec      = 1'b0;
      cnt_load_val = '0;
      case (state_reg)
         ST_IDLE: begin
            if (accept) begin
               case (cht_op_e'(cmd.cmd_op))
                  OP_CLEAR: state_next = ST_CLR;
                  OP_LOAD: begin
                     state_next = ST_LOAD;
                     mask_next  = sel_mask;
                  end
                  OP_SHIFT: begin
                     if (cmd.cmd_count == '0) begin
                        state_next = ST_DONE;
                     end else if (count_ext > limit) begin
                        state_next = ST_DONE;
                        err_next   = 1'b1;
                     end else begin
                        // Counter holds remaining strobes minus one so zero flags the final cycle.
                        state_next   = ST_SHIFT;
                        mask_next    = sel_mask;
                        cnt_load     = 1'b1;
                        cnt_load_val = cmd.cmd_count - CNT_W'(1);
                     end
                  end
                  default: state_next = ST_DONE;
               endcase
            end
         end
         ST_CLR:  state_next = ST_DONE;
         ST_LOAD: state_next = ST_DONE;
         ST_SHIFT: begin
            cnt_dec = 1'b1;
            if (abort || cnt_zero) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so every strobe leaves a flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         mask_reg  <= '0;
         ready_reg <= 1'b0;
         load_en   <= '0;
         shift_en  <= '0;
         clear     <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state_reg <= state_next;
         mask_reg  <= mask_next;
         ready_reg <= (state_next == ST_IDLE);
         load_en   <= (state_next == ST_LOAD)  ? mask_next : 3'b000;
         shift_en  <= (state_next == ST_SHIFT) ? mask_next : 3'b000;
         clear     <= (state_next == ST_CLR);
         done      <= (state_next == ST_DONE);
         err       <= err_next;
      end
   end

   assign cmd.cmd_ready = ready_reg;
   assign busy          = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_cht_seq_ctrl.sv
// Directed bench for cht_seq_ctrl: one line per command, checks every cycle of each.
module tb_cht_seq_ctrl;
   import cht_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       abort = 1'b0;
   logic [2:0] load_en, shift_en;
   logic       clear, busy, done, err;
   int         checks = 0;
   int         failures = 0;

   cht_seq_ctrl_if #(.CNT_W(5)) cmd_bus ();

   cht_seq_ctrl dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cmd      (cmd_bus),
      .abort    (abort),
      .load_en  (load_en),
      .shift_en (shift_en),
      .clear    (clear),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Check every output for the current cycle, then advance to the next sample point.
   task automatic cyc(input string tag, input logic [2:0] el, input logic [2:0] es,
                      input logic ec, input logic ed, input logic ee, input logic er);
      chk3({tag, ".load_en"}, load_en, el);
      chk3({tag, ".shift_en"}, shift_en, es);
      chk1({tag, ".clear"}, clear, ec);
      chk1({tag, ".done"}, done, ed);
      chk1({tag, ".err"}, err, ee);
      chk1({tag, ".cmd_ready"}, cmd_bus.cmd_ready, er);
      chk1({tag, ".busy"}, busy, !er);
      @(negedge clk);
   endtask

   task automatic issue(input logic [1:0] op, input logic [1:0] chain, input logic [4:0] count);
      int n = 0;
      while (!cmd_bus.cmd_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk1("ready_wait", cmd_bus.cmd_ready, 1'b1);
      $display("txn op=%0d chain=%0d count=%0d t=%0t", op, chain, count, $time);
      cmd_bus.cmd_valid = 1'b1;
      cmd_bus.cmd_op    = op;
      cmd_bus.cmd_chain = chain;
      cmd_bus.cmd_count = count;
      @(negedge clk);
      cmd_bus.cmd_valid = 1'b0;
      cmd_bus.cmd_op    = 2'($urandom_range(3));
      cmd_bus.cmd_chain = 2'($urandom_range(3));
      cmd_bus.cmd_count = 5'($urandom_range(31));
   endtask

   initial begin
      cmd_bus.cmd_valid = 1'b0;
      cmd_bus.cmd_op    = 2'b00;
      cmd_bus.cmd_chain = 2'b00;
      cmd_bus.cmd_count = 5'd0;

      // Reset
      #3 rst_n = 1'b0;
      #1;
      chk1("rst.cmd_ready", cmd_bus.cmd_ready, 1'b0);
      chk1("rst.busy", busy, 1'b0);
      chk1("rst.done", done, 1'b0);
      chk3("rst.shift_en", shift_en, 3'b000);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk1("rel.cmd_ready_low", cmd_bus.cmd_ready, 1'b0);
      @(negedge clk);
      cyc("rel", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);

      // CLEAR: clear at cycle 1, done at cycle 2, ready at cycle 3
      issue(OP_CLEAR, 2'd0, 5'd0);
      cyc("clr.c1", 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("clr.c2", 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("clr.c3", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);

      // NOP
      issue(OP_NOP, 2'd2, 5'd9);
      cyc("nop.c1", 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("nop.c2", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);

      // LOAD all chains, then chain B
      issue(OP_LOAD, 2'd3, 5'd0);
      cyc("ldall.c1", 3'b111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("ldall.c2", 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("ldall.c3", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
      issue(OP_LOAD, 2'd1, 5'd0);
      cyc("ldB.c1", 3'b010, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("ldB.c2", 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("ldB.c3", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);

      // SHIFT chain B, count 14 (exact length)
      issue(OP_SHIFT, 2'd1, 5'd14);
      for (int i = 0; i < 14; i++)
         cyc("shB14.strobe", 3'b000, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("shB14.done", 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("shB14.idle", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);

      // SHIFT chain B, count 15 (over length)
      issue(OP_SHIFT, 2'd1, 5'd15);
      cyc("shB15.done", 3'b000, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0);
      cyc("shB15.idle", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);

      // SHIFT chain C, count 10, abort on the 4th strobe cycle
      issue(OP_SHIFT, 2'd2, 5'd10);
      for (int i = 0; i < 3; i++)
         cyc("shC.strobe", 3'b000, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
      abort = 1'b1;
      cyc("shC.strobe4", 3'b000, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
      abort = 1'b0;
      cyc("shC.abort_done", 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("shC.idle", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);

      // SHIFT chain A, count 0
      issue(OP_SHIFT, 2'd0, 5'd0);
      cyc("shA0.done", 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("shA0.idle", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);

      // SHIFT chain A, count 6 with abort high only at acceptance (ignored in IDLE)
      abort = 1'b1;
      issue(OP_SHIFT, 2'd0, 5'd6);
      abort = 1'b0;
      for (int i = 0; i < 6; i++)
         cyc("shA6.strobe", 3'b000, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("shA6.done", 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("shA6.idle", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);

      // SHIFT all chains: count 3 in range, count 17 above max length
      issue(OP_SHIFT, 2'd3, 5'd3);
      for (int i = 0; i < 3; i++)
         cyc("shall3.strobe", 3'b000, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("shall3.done", 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("shall3.idle", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
      issue(OP_SHIFT, 2'd3, 5'd17);
      cyc("shall17.done", 3'b000, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0);
      cyc("shall17.idle", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);

      // Reset pulsed in the middle of a SHIFT
      issue(OP_SHIFT, 2'd2, 5'd10);
      cyc("shrst.strobe", 3'b000, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("shrst.strobe", 3'b000, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk3("shrst.async_shift_en", shift_en, 3'b000);
      chk1("shrst.async_busy", busy, 1'b0);
      chk1("shrst.async_ready", cmd_bus.cmd_ready, 1'b0);
      chk1("shrst.async_done", done, 1'b0);
      @(negedge clk);
      chk1("shrst.hold_done", done, 1'b0);
      rst_n = 1'b1;
      #1 chk1("shrst.rel_ready_low", cmd_bus.cmd_ready, 1'b0);
      @(negedge clk);
      cyc("shrst.rel1", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc("shrst.rel2", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
